keypad_scanner: RTL and testbench

Scans a 4x4 active-low key matrix, synchronises and debounces the row inputs, and encodes each accepted press into the calculator key code. It is the producing end of the `ready`/`tecla` key interface consumed by the calculator operation controller. Each debounced press yields exactly one single-cycle `ready` pulse with a stable `tecla`. Held keys, bounces, and unmapped positions produce no pulse.

---
 rtl/keypad_scanner.sv | 185 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix, synchronises and
// debounces the rows, and emits one ready pulse per accepted key press
// together with its calculator key code on tecla.
//
//   state          | meaning
//   ---------------+--------------------------------------------------
//   S_SCAN         | drive one column per SCAN_DIV cycles, look for a low row
//   S_DEBOUNCE     | column held, row must stay low DEBOUNCE_CYCLES cycles
//   S_EMIT         | one-cycle ready pulse, tecla already updated
//   S_WAIT_RELEASE | column held until all rows high DEBOUNCE_CYCLES cycles
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       clearIn,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] tecla,
  output logic       ready,
  output logic       busy
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_EMIT,
    S_WAIT_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       sync_meta_q;
  logic [3:0]       sync_rows_q;
  logic [1:0]       col_q, col_d;
  logic [1:0]       key_row_q, key_row_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [DEB_W-1:0] rel_cnt_q, rel_cnt_d;
  logic [3:0]       tecla_q, tecla_d;

  logic [1:0]       low_row;
  logic             key_row_low;
  logic             all_high;
  logic             key_mapped;
  logic [3:0]       key_code;

  // Row / column position to calculator code; r3/c3 is the only unmapped key.
  function automatic logic [4:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [4:0] res;
    unique case ({r, c})
      4'b00_00: res = {1'b1, 4'b0001};
      4'b00_01: res = {1'b1, 4'b0010};
      4'b00_10: res = {1'b1, 4'b0011};
      4'b00_11: res = {1'b1, 4'b1100};
      4'b01_00: res = {1'b1, 4'b0100};
      4'b01_01: res = {1'b1, 4'b0101};
      4'b01_10: res = {1'b1, 4'b0110};
      4'b01_11: res = {1'b1, 4'b1011};
      4'b10_00: res = {1'b1, 4'b0111};
      4'b10_01: res = {1'b1, 4'b1000};
      4'b10_10: res = {1'b1, 4'b1001};
      4'b10_11: res = {1'b1, 4'b1101};
      4'b11_00: res = {1'b1, 4'b1110};
      4'b11_01: res = {1'b1, 4'b0000};
      4'b11_10: res = {1'b1, 4'b1111};
      default:  res = {1'b0, 4'b0000};
    endcase
    return res;
  endfunction

  // Decode helpers: lowest low row wins, and key lookup for the held position.
  always_comb begin
    low_row = 2'd3;
    if (!sync_rows_q[0])      low_row = 2'd0;
    else if (!sync_rows_q[1]) low_row = 2'd1;
    else if (!sync_rows_q[2]) low_row = 2'd2;
    all_high    = &sync_rows_q;
    key_row_low = ~sync_rows_q[key_row_q];
    {key_mapped, key_code} = key_lookup(key_row_q, col_q);
  end

  // State and datapath registers, including the two-flop row synchroniser.
  always_ff @(posedge Clock) begin
    if (!clearIn) begin
      sync_meta_q <= 4'b1111;
      sync_rows_q <= 4'b1111;
      state_q     <= S_SCAN;
      col_q       <= 2'd0;
      key_row_q   <= 2'd0;
      div_cnt_q   <= '0;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      tecla_q     <= 4'b0000;
    end else begin
      sync_meta_q <= rows;
      sync_rows_q <= sync_meta_q;
      state_q     <= state_d;
      col_q       <= col_d;
      key_row_q   <= key_row_d;
      div_cnt_q   <= div_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      tecla_q     <= tecla_d;
    end
  end

  // Next-state and counter updates.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    key_row_d = key_row_q;
    div_cnt_d = div_cnt_q;
    deb_cnt_d = deb_cnt_q;
    rel_cnt_d = rel_cnt_q;
    tecla_d   = tecla_q;
    unique case (state_q)
      S_SCAN: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (all_high) begin
            col_d = col_q + 2'd1;
          end else begin
            key_row_d = low_row;
            deb_cnt_d = '0;
            state_d   = S_DEBOUNCE;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_DEBOUNCE: begin
        if (!key_row_low) begin
          // Bounce or glitch: abandon this key and move on to the next column.
          state_d   = S_SCAN;
          col_d     = col_q + 2'd1;
          div_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          rel_cnt_d = '0;
          if (key_mapped) begin
            tecla_d = key_code;
            state_d = S_EMIT;
          end else begin
            state_d = S_WAIT_RELEASE;
          end
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      S_EMIT: begin
        rel_cnt_d = '0;
        state_d   = S_WAIT_RELEASE;
      end
      S_WAIT_RELEASE: begin
        // Any low row (even another key) restarts the release timer.
        if (!all_high) begin
          rel_cnt_d = '0;
        end else if (rel_cnt_q == DEB_LAST) begin
          state_d   = S_SCAN;
          col_d     = col_q + 2'd1;
          div_cnt_d = '0;
        end else begin
          rel_cnt_d = rel_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_SCAN;
        div_cnt_d = '0;
      end
    endcase
  end

  // Outputs: one-cold column drive, ready only in EMIT, busy outside SCAN.
  always_comb begin
    cols  = ~(4'b0001 << col_q);
    ready = (state_q == S_EMIT);
    busy  = (state_q != S_SCAN);
    tecla = tecla_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: models the key matrix, queues expected key
// codes as presses are issued and checks them whenever ready is seen.
module tb_keypad_scanner;

  logic       Clock;
  logic       clearIn;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] tecla;
  logic       ready;
  logic       busy;

  logic [15:0] pressed;  // bit r*4+c set = key at row r / column c held
  logic [3:0]  exp_q[$];
  int          tests;
  int          fails;
  int          pulse_cnt;
  int          exp_pulses;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .Clock   (Clock),
    .clearIn (clearIn),
    .rows    (rows),
    .cols    (cols),
    .tecla   (tecla),
    .ready   (ready),
    .busy    (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Matrix model: a held key pulls its row low while its column is driven.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    logic       prev_ready;
    logic [3:0] e;
    prev_ready = 1'b0;
    forever begin
      @(negedge Clock);
      if (ready) begin
        pulse_cnt++;
        check("ready_single_cycle", 32'(prev_ready), 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: tecla=%b, no press was expected", tecla);
        end else begin
          e = exp_q.pop_front();
          check("tecla_on_ready", 32'(tecla), 32'(e));
        end
      end
      prev_ready = ready;
    end
  endtask

  task automatic press(input int r, input int c);
    pressed[r*4+c] = 1'b1;
  endtask

  task automatic unpress(input int r, input int c);
    pressed[r*4+c] = 1'b0;
  endtask

  task automatic expect_key(input logic [3:0] code);
    exp_q.push_back(code);
    exp_pulses++;
  endtask

  task automatic wait_pulses(input string name, input int budget);
    int n;
    n = 0;
    while (pulse_cnt < exp_pulses && n < budget) begin
      @(negedge Clock);
      n++;
    end
    @(negedge Clock);
    check(name, pulse_cnt, exp_pulses);
  endtask

  task automatic wait_busy(input string name, input logic val, input int budget);
    int n;
    n = 0;
    while (busy !== val && n < budget) begin
      @(negedge Clock);
      n++;
    end
    check(name, 32'(busy), 32'(val));
  endtask

  task automatic release_all(input string name);
    pressed = '0;
    wait_busy(name, 1'b0, 200);
  endtask

  initial begin
    int n;
    int start;
    tests      = 0;
    fails      = 0;
    pulse_cnt  = 0;
    exp_pulses = 0;
    pressed    = '0;
    clearIn    = 1'b0;
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (3) @(negedge Clock);
    check("rst_cols",  32'(cols),  32'(4'b1110));
    check("rst_tecla", 32'(tecla), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_busy",  32'(busy),  0);
    clearIn = 1'b1;
    repeat (4) @(negedge Clock);

    // r1/c1 held 200 cycles, then released
    expect_key(4'b0101);
    press(1, 1);
    wait_pulses("t1_pulse", 100);
    start = pulse_cnt;
    repeat (200) @(negedge Clock);
    check("t1_no_repeat", pulse_cnt, start);
    check("t1_busy_held", 32'(busy), 1);
    pressed = '0;
    n = 0;
    while (busy && n < 50) begin
      @(negedge Clock);
      n++;
    end
    tests++;
    if (n < 8 || n > 10) begin
      fails++;
      $display("FAIL t1_busy_fall: busy fell %0d cycles after release, need 8..10", n);
    end
    repeat (10) @(negedge Clock);

    // r2/c3 with bounce
    n = 0;
    while (cols !== 4'b0111 && n < 50) begin
      @(negedge Clock);
      n++;
    end
    check("t2_col3_reached", 32'(cols), 32'(4'b0111));
    start = pulse_cnt;
    expect_key(4'b1101);
    press(2, 3);   repeat (3) @(negedge Clock);
    unpress(2, 3); repeat (2) @(negedge Clock);
    press(2, 3);   repeat (3) @(negedge Clock);
    check("t2_no_pulse_in_bounce", pulse_cnt, start);
    wait_pulses("t2_pulse", 150);
    release_all("t2_idle");
    repeat (10) @(negedge Clock);

    // r0/c2 + r2/c2 together, partial release
    expect_key(4'b0011);
    press(0, 2);
    press(2, 2);
    wait_pulses("t3_pulse", 100);
    start = pulse_cnt;
    unpress(0, 2);
    repeat (40) @(negedge Clock);
    check("t3_partial_busy", 32'(busy), 1);
    check("t3_partial_no_pulse", pulse_cnt, start);
    release_all("t3_idle");
    repeat (10) @(negedge Clock);

    // r3/c3 unmapped
    start = pulse_cnt;
    press(3, 3);
    wait_busy("t4_busy_rise", 1'b1, 100);
    repeat (40) @(negedge Clock);
    check("t4_no_pulse", pulse_cnt, start);
    check("t4_tecla_kept", 32'(tecla), 32'(4'b0011));
    release_all("t4_idle");
    repeat (10) @(negedge Clock);

    // reset mid-DEBOUNCE on r0/c0, then re-detection
    start = pulse_cnt;
    press(0, 0);
    wait_busy("t5_debounce_entered", 1'b1, 100);
    repeat (2) @(negedge Clock);
    clearIn = 1'b0;
    @(negedge Clock);
    clearIn = 1'b1;
    check("t5_rst_cols",  32'(cols),  32'(4'b1110));
    check("t5_rst_tecla", 32'(tecla), 0);
    check("t5_rst_busy",  32'(busy),  0);
    check("t5_no_pulse",  pulse_cnt, start);
    expect_key(4'b0001);
    wait_pulses("t5_redetect_pulse", 100);
    release_all("t5_idle");
    repeat (10) @(negedge Clock);

    // sequence r0/c3, r2/c0, r2/c3 with 30 idle cycles between
    expect_key(4'b1100);
    press(0, 3);
    wait_pulses("t6_pulse_add", 100);
    release_all("t6_idle_add");
    repeat (30) @(negedge Clock);
    expect_key(4'b0111);
    press(2, 0);
    wait_pulses("t6_pulse_7", 100);
    release_all("t6_idle_7");
    repeat (30) @(negedge Clock);
    expect_key(4'b1101);
    press(2, 3);
    wait_pulses("t6_pulse_igual", 100);
    release_all("t6_idle_igual");
    repeat (30) @(negedge Clock);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_pulse_total", pulse_cnt, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
